// File: rtl/nfu_1_sched.sv
// NFU-1 tile-pass sequencer: walks ni inside no, issues NBin/SB reads and
// carries valid/first/last/out_idx tags so they reach NFU-2 with the products.
module nfu_1_sched #(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8,
    parameter int NFU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [CNT_W-1:0]  i_cmd_ni_m1,
    input  logic [CNT_W-1:0]  i_cmd_no_m1,
    input  logic [ADDR_W-1:0] i_cmd_nbin_base,
    input  logic [ADDR_W-1:0] i_cmd_sb_base,
    input  logic              i_stall,
    output logic              o_nbin_rd,
    output logic [ADDR_W-1:0] o_nbin_addr,
    output logic              o_sb_rd,
    output logic [ADDR_W-1:0] o_sb_addr,
    output logic              o_stage_en,
    output logic              o_acc_valid,
    output logic              o_acc_first,
    output logic              o_acc_last,
    output logic [CNT_W-1:0]  o_acc_out_idx,
    output logic              o_busy,
    output logic              o_done
);
    localparam int STAGES = NFU_LAT + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // fin marks the final beat of the pass so DRAIN knows when the pipe is empty
    typedef struct packed {
        logic             vld;
        logic             first;
        logic             last;
        logic             fin;
        logic [CNT_W-1:0] idx;
    } tag_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    ni_q, no_q, ni_m1_q, no_m1_q;
    logic [CNT_W-1:0]    ni_d, no_d;
    logic [ADDR_W-1:0]   nbin_base_q, nbin_addr_q, sb_addr_q;
    tag_t [STAGES-1:0]   tag_q;
    tag_t                tag_d, tail;
    logic                issue, ni_last, no_last;

    assign issue   = (state_q == ISSUE) && !i_stall;
    assign ni_last = (ni_q == ni_m1_q);
    assign no_last = (no_q == no_m1_q);
    assign tail    = tag_q[STAGES-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_cmd_valid) state_d = ISSUE;
            ISSUE:   if (issue && ni_last && no_last) state_d = DRAIN;
            DRAIN:   if (tail.vld && tail.fin && !i_stall) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ni_d = ni_last ? '0 : ni_q + 1'b1;
        no_d = ni_last ? no_q + 1'b1 : no_q;
        tag_d = '0;
        if (issue) begin
            tag_d.vld   = 1'b1;
            tag_d.first = (ni_q == '0);
            tag_d.last  = ni_last;
            tag_d.fin   = ni_last && no_last;
            tag_d.idx   = no_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ni_q        <= '0;
            no_q        <= '0;
            ni_m1_q     <= '0;
            no_m1_q     <= '0;
            nbin_base_q <= '0;
            nbin_addr_q <= '0;
            sb_addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && i_cmd_valid) begin
                ni_q        <= '0;
                no_q        <= '0;
                ni_m1_q     <= i_cmd_ni_m1;
                no_m1_q     <= i_cmd_no_m1;
                nbin_base_q <= i_cmd_nbin_base;
                nbin_addr_q <= i_cmd_nbin_base;
                sb_addr_q   <= i_cmd_sb_base;
            end else if (issue) begin
                ni_q        <= ni_d;
                no_q        <= no_d;
                // Address for the next beat is precomputed so the port is a flop
                nbin_addr_q <= nbin_base_q + ADDR_W'(ni_d);
                sb_addr_q   <= sb_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           tag_q[0] <= '0;
        else if (!i_stall) tag_q[0] <= tag_d;
    end

    for (genvar s = 1; s < STAGES; s++) begin : g_tag
        always_ff @(posedge clk) begin
            if (rst)           tag_q[s] <= '0;
            else if (!i_stall) tag_q[s] <= tag_q[s-1];
        end
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == DONE);
    assign o_nbin_rd     = issue;
    assign o_sb_rd       = issue;
    assign o_nbin_addr   = nbin_addr_q;
    assign o_sb_addr     = sb_addr_q;
    assign o_stage_en    = !i_stall;
    assign o_acc_valid   = tail.vld && !i_stall;
    assign o_acc_first   = o_acc_valid && tail.first;
    assign o_acc_last    = o_acc_valid && tail.last;
    assign o_acc_out_idx = o_acc_valid ? tail.idx : '0;

endmodule
